// File: rtl/fetch_queue_if.sv
// fetch_queue_if: bundles the fetch front-end's redirect, instruction-memory
// and decode-side signals.
//   master : the fetch queue (drives imem_addr, out_*, count[, perf_*])
//   slave  : the surrounding pipeline / memory model
// Ports inside the bundle:
//   redirect_valid/redirect_pc  EX-resolved control transfer and target
//   imem_addr/imem_rdata        combinational instruction memory read
//   out_valid/out_ready         decode handshake
//   out_pc/out_instr/out_pc_plus4  head entry presented to decode
//   count                       occupied FIFO entries
//   perf_fetched/perf_flushed   only when FETCH_PERF_EN is defined
interface fetch_queue_if #(
  parameter int DWIDTH = 32,
  parameter int DEPTH  = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic              redirect_valid;
  logic [DWIDTH-1:0] redirect_pc;
  logic [DWIDTH-1:0] imem_addr;
  logic [DWIDTH-1:0] imem_rdata;
  logic              out_valid;
  logic              out_ready;
  logic [DWIDTH-1:0] out_pc;
  logic [DWIDTH-1:0] out_instr;
  logic [DWIDTH-1:0] out_pc_plus4;
  logic [CW-1:0]     count;
`ifdef FETCH_PERF_EN
  logic [31:0]       perf_fetched;
  logic [31:0]       perf_flushed;

  modport master (
    input  redirect_valid, redirect_pc, imem_rdata, out_ready,
    output imem_addr, out_valid, out_pc, out_instr, out_pc_plus4, count,
    output perf_fetched, perf_flushed
  );
  modport slave (
    output redirect_valid, redirect_pc, imem_rdata, out_ready,
    input  imem_addr, out_valid, out_pc, out_instr, out_pc_plus4, count,
    input  perf_fetched, perf_flushed
  );
`else
  modport master (
    input  redirect_valid, redirect_pc, imem_rdata, out_ready,
    output imem_addr, out_valid, out_pc, out_instr, out_pc_plus4, count
  );
  modport slave (
    output redirect_valid, redirect_pc, imem_rdata, out_ready,
    input  imem_addr, out_valid, out_pc, out_instr, out_pc_plus4, count
  );
`endif
endinterface

// File: rtl/fetch_queue.sv
// fetch_queue: instruction fetch front-end. Owns the fetch PC, reads the
// combinational instruction memory every cycle, buffers {pc, instr} pairs in
// a DEPTH-entry FIFO and hands them to decode over valid/ready. A redirect
// from EX flushes the FIFO and restarts fetch at the (word-aligned) target.
// Ports:
//   clk  clock
//   rst  synchronous active-high reset
//   bus  fetch_queue_if.master (redirect, imem, decode handshake, count)
// Optional: define FETCH_PERF_EN to add perf_fetched / perf_flushed
// saturating counters on the bus.
module fetch_queue #(
  parameter int                 DWIDTH   = 32,
  parameter int                 DEPTH    = 4,
  parameter logic [DWIDTH-1:0]  RESET_PC = '0
) (
  input  logic          clk,
  input  logic          rst,
  fetch_queue_if.master bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [DWIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]     count_q, count_d;

  // NOTE: FIFO storage is deliberately not reset; pointers and count alone
  // decide which entries are live, so stale contents are never observed.
  logic [DWIDTH-1:0] pc_mem    [DEPTH];
  logic [DWIDTH-1:0] instr_mem [DEPTH];

  logic out_valid;
  logic pop;
  logic push;

  // Redirect hides the head combinationally so no stale entry is accepted.
  assign out_valid = (count_q != '0) && !bus.redirect_valid;
  assign pop       = out_valid && bus.out_ready;
  // A pop frees a slot this same edge, so a full queue keeps fetching.
  assign push      = !bus.redirect_valid && ((count_q < DEPTH_C) || pop);

  assign bus.imem_addr    = fetch_pc_q;
  assign bus.out_valid    = out_valid;
  assign bus.out_pc       = out_valid ? pc_mem[rd_ptr_q] : '0;
  assign bus.out_instr    = out_valid ? instr_mem[rd_ptr_q] : '0;
  assign bus.out_pc_plus4 = out_valid ? pc_mem[rd_ptr_q] + DWIDTH'(4) : '0;
  assign bus.count        = count_q;

  always_comb begin
    // NOTE: every variable gets a default first so no path infers a latch.
    fetch_pc_d = fetch_pc_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    if (bus.redirect_valid) begin
      fetch_pc_d = {bus.redirect_pc[DWIDTH-1:2], 2'b00};
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
    end else begin
      if (push) begin
        fetch_pc_d = fetch_pc_q + DWIDTH'(4);
        wr_ptr_d   = wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      unique case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr_q]    <= fetch_pc_q;
      instr_mem[wr_ptr_q] <= bus.imem_rdata;
    end
  end

`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched_q, perf_fetched_d;
  logic [31:0] perf_flushed_q, perf_flushed_d;
  logic [32:0] flush_sum;

  // One extra bit catches overflow so the counter saturates instead of wrapping.
  assign flush_sum = {1'b0, perf_flushed_q} + 33'(count_q);

  always_comb begin
    perf_fetched_d = perf_fetched_q;
    perf_flushed_d = perf_flushed_q;
    if (push && (perf_fetched_q != '1)) begin
      perf_fetched_d = perf_fetched_q + 32'd1;
    end
    if (bus.redirect_valid) begin
      perf_flushed_d = flush_sum[32] ? '1 : flush_sum[31:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetched_q <= '0;
      perf_flushed_q <= '0;
    end else begin
      perf_fetched_q <= perf_fetched_d;
      perf_flushed_q <= perf_flushed_d;
    end
  end

  assign bus.perf_fetched = perf_fetched_q;
  assign bus.perf_flushed = perf_flushed_q;
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed bench for fetch_queue. The instruction memory is
// modelled as instr = addr ^ 32'hA5A5A5A5. Inputs change and outputs are
// sampled 2 time units after each rising edge.
module tb_fetch_queue;
  localparam int DWIDTH = 32;
  localparam int DEPTH  = 4;
  localparam logic [31:0] KEY = 32'hA5A5A5A5;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  fetch_queue_if #(.DWIDTH(DWIDTH), .DEPTH(DEPTH)) bus ();

  fetch_queue #(.DWIDTH(DWIDTH), .DEPTH(DEPTH), .RESET_PC('0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  assign bus.imem_rdata = bus.imem_addr ^ KEY;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Head-of-queue check: valid, pc, instr and pc+4 all from the bench's model.
  task automatic check_head(input string tag, input logic [31:0] pc);
    check({tag, ".valid"}, 32'(bus.out_valid), 32'd1);
    check({tag, ".pc"},    bus.out_pc,         pc);
    check({tag, ".instr"}, bus.out_instr,      pc ^ KEY);
    check({tag, ".pc4"},   bus.out_pc_plus4,   pc + 32'd4);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst                = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.out_ready      = 1'b1;

    // Reset state
    tick();
    tick();
    check("rst.count", 32'(bus.count),     32'd0);
    check("rst.valid", 32'(bus.out_valid), 32'd0);
    check("rst.pc",    bus.out_pc,         32'd0);
    check("rst.instr", bus.out_instr,      32'd0);
    check("rst.pc4",   bus.out_pc_plus4,   32'd0);
    check("rst.addr",  bus.imem_addr,      32'd0);
`ifdef FETCH_PERF_EN
    check("rst.perf_fetched", bus.perf_fetched, 32'd0);
    check("rst.perf_flushed", bus.perf_flushed, 32'd0);
`endif

    // Streaming with ready=1: one entry per cycle, sequential PCs
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      check_head($sformatf("stream%0d", k), 32'(4 * k));
      check($sformatf("stream%0d.count", k), 32'(bus.count), 32'd1);
      check($sformatf("stream%0d.addr", k),  bus.imem_addr,  32'(4 * (k + 1)));
    end

    // Backpressure: fill to DEPTH then stall fetch at 0x10
    rst           = 1'b1;
    bus.out_ready = 1'b0;
    tick();
    check("bp.rst.count", 32'(bus.count), 32'd0);
    rst = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      tick();
      check($sformatf("bp%0d.count", i), 32'(bus.count),  32'((i < 4) ? i : 4));
      check($sformatf("bp%0d.addr", i),  bus.imem_addr,   32'(4 * ((i < 4) ? i : 4)));
    end
    check_head("bp.head", 32'h0);

    // Full with steady ready: push+pop each cycle, count pinned at DEPTH
    bus.out_ready = 1'b1;
    for (int j = 0; j < 6; j++) begin
      tick();
      check_head($sformatf("full%0d", j), 32'(4 * (j + 1)));
      check($sformatf("full%0d.count", j), 32'(bus.count), 32'd4);
      check($sformatf("full%0d.addr", j),  bus.imem_addr,  32'(32'h14 + 4 * j));
    end

    // Ten pushes ending at count=3, then redirect to unaligned 0x103
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    bus.out_ready = 1'b0;
    tick();
    tick();
    check("pre_redir.count", 32'(bus.count), 32'd3);
    check_head("pre_redir", 32'h1C);
    check("pre_redir.addr", bus.imem_addr, 32'h28);
    bus.out_ready      = 1'b1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h103;
    #1;
    check("redir.same.valid", 32'(bus.out_valid), 32'd0);
    check("redir.same.pc",    bus.out_pc,         32'd0);
    tick();
    bus.redirect_valid = 1'b0;
    #1;
    check("redir.n1.count", 32'(bus.count),     32'd0);
    check("redir.n1.valid", 32'(bus.out_valid), 32'd0);
    check("redir.n1.addr",  bus.imem_addr,      32'h100);
`ifdef FETCH_PERF_EN
    check("perf_fetched", bus.perf_fetched, 32'd10);
    check("perf_flushed", bus.perf_flushed, 32'd3);
`endif
    tick();
    check_head("redir.n2", 32'h100);
    check("redir.n2.count", 32'(bus.count), 32'd1);
    tick();
    check_head("redir.n3", 32'h104);

    // Mid-stream reset with two entries queued
    bus.out_ready = 1'b0;
    tick();
    check("mid.count", 32'(bus.count), 32'd2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst.count", 32'(bus.count),     32'd0);
    check("mid_rst.valid", 32'(bus.out_valid), 32'd0);
    check("mid_rst.addr",  bus.imem_addr,      32'h0);

    // Redirect near the top of the address space: PC and pc+4 wrap to 0
    bus.out_ready      = 1'b1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'hFFFF_FFFA;
    tick();
    bus.redirect_valid = 1'b0;
    #1;
    check("wrap.addr", bus.imem_addr, 32'hFFFF_FFF8);
    tick();
    check_head("wrap0", 32'hFFFF_FFF8);
    tick();
    check_head("wrap1", 32'hFFFF_FFFC);
    check("wrap1.pc4", bus.out_pc_plus4, 32'h0);
    tick();
    check_head("wrap2", 32'h0);
    tick();
    check_head("wrap3", 32'h4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
Instruction fetch front-end between the combinational instruction memory and the IF/ID pipeline register.
- Owns the fetch PC and drives the imem address.
- Buffers fetched {pc, instr} pairs in a small FIFO.
- Presents them to decode over a valid/ready handshake.
- Accepts a one-cycle redirect from EX (branch/jump resolution) that flushes all buffered work.

Parameters:
DWIDTH, 32, data/address width
DEPTH, 4, FIFO entries; power of two, >= 2
RESET_PC, 0, fetch PC loaded on reset; word aligned

Ports:
clk  input  1  clock
rst  input  1  reset
redirect_valid  input  1  EX-resolved control transfer; flush and refetch this cycle
redirect_pc  input  DWIDTH  redirect target
imem_addr  output  DWIDTH  instruction memory address (combinational read, data same cycle)
imem_rdata  input  DWIDTH  instruction word at imem_addr
out_valid  output  1  head entry available to decode
out_ready  input  1  decode accepts head entry
out_pc  output  DWIDTH  PC of head entry
out_instr  output  DWIDTH  instruction of head entry
out_pc_plus4  output  DWIDTH  out_pc + 4 (for JAL link)
count  output  $clog2(DEPTH)+1  occupied entries

Behaviour:
- Reset: rst is synchronous, active-high; clock is clk.
  - fetch_pc <= RESET_PC, rd/wr pointers <= 0, count <= 0.
  - Consequently out_valid=0, out_pc=0, out_instr=0, out_pc_plus4=0.
  - Reset asserted mid-operation discards all entries identically.
- imem_addr = fetch_pc (combinational).
- pop = out_valid && out_ready.
- push = !redirect_valid && (count < DEPTH || pop).
  - On push: write {fetch_pc, imem_rdata} at wr pointer; fetch_pc <= fetch_pc + 4.
  - Otherwise fetch_pc holds (stall under backpressure, no refetch gaps).
- Full with simultaneous pop: push still occurs, count stays DEPTH.
- Empty: pop impossible because out_valid=0.
- Redirect (priority over push/pop/normal update):
  - fetch_pc <= {redirect_pc[DWIDTH-1:2], 2'b00}.
  - Pointers and count <= 0.
  - No push that cycle.
  - out_valid is forced 0 combinationally while redirect_valid=1, so no handshake completes in the redirect cycle.
- out_valid = (count != 0) && !redirect_valid.
- When out_valid=0, out_pc/out_instr/out_pc_plus4 drive 0; otherwise they drive the head entry.
- Latency:
  - First entry visible the cycle after rst deasserts, with out_pc=RESET_PC.
  - Redirect sampled at edge N: redirect_pc is fetched in cycle N+1 and appears on out_* with out_valid=1 in cycle N+2.
- Pointer wrap: modulo DEPTH.
- fetch_pc wraps modulo 2^DWIDTH (0xFFFFFFFC + 4 = 0).
- out_pc_plus4 also wraps.
- FIFO storage needs no reset; only pointers/count are reset.

Optional Feature:
Macro FETCH_PERF_EN.
- When defined, adds outputs perf_fetched (32, input-to-FIFO push count) and perf_flushed (32, entries discarded by redirect).
- perf_flushed adds the value of count in each redirect cycle.
- Both counters reset to 0, saturate at 0xFFFFFFFF, and are cleared by rst.
- When undefined, these ports and registers do not exist; all other behaviour is identical.

Test Plan:
- Reset, out_ready=1, imem returns addr^0xA5A5A5A5 -> out_pc 0,4,8,... each cycle from the first post-reset cycle; out_instr matches; out_pc_plus4 = out_pc+4.
- out_ready=0 for 8 cycles after reset -> count climbs 1..4 and holds; imem_addr holds at 0x10; releasing ready drains pc 0,4,8,C, then 0x10 with no gap.
- Full (count=4) with out_ready=1 steady -> push+pop each cycle, count stays 4, PCs strictly sequential.
- Redirect to 0x103 while count=3 -> same cycle out_valid=0, next cycle count=0 and imem_addr=0x100, following cycle out_pc=0x100; no stale PC ever accepted.
- rst asserted for 1 cycle mid-stream with count=2 -> next cycle count=0, out_valid=0, imem_addr=RESET_PC; fetch_pc preset to 0xFFFFFFF8 via redirect -> out_pc sequence ...F8, ...FC, 0, 4.
- FETCH_PERF_EN build: 10 pushes then redirect at count=3 -> perf_fetched=10, perf_flushed=3; undefined build compiles without the ports.
